// File: rtl/reg_lock_file_pkg.sv
// reg_lock_file_pkg: shared widths and constants for the register lock file
package reg_lock_file_pkg;
  localparam int DATA_W = 32;
  localparam int LOCK_W = 3;
  localparam int ADDR_W = 5;
  localparam int NREG = 32;
  localparam int CNT_W = 6;
  localparam logic [LOCK_W-1:0] NO_LOCK = '0;
endpackage

// File: rtl/reg_lock_entry.sv
// reg_lock_entry: one renamed register (data + producer tag) with CDB match/clear
import reg_lock_file_pkg::*;
module reg_lock_entry #(
  parameter int DW = DATA_W,
  parameter int LW = LOCK_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_i,
  input  logic [LW-1:0] alloc_lock_i,
  input  logic          cdb_valid_i,
  input  logic [LW-1:0] cdb_index_i,
  input  logic [DW-1:0] cdb_result_i,
  input  logic          flush_i,
  output logic [DW-1:0] data_o,
  output logic [LW-1:0] lock_o,
  output logic          match_o,
  output logic          inc_o,
  output logic          dec_o
);
  logic [DW-1:0] data_q, data_d;
  logic [LW-1:0] lock_q, lock_d;
  always_comb begin
    match_o = cdb_valid_i && lock_q != LW'(0) && lock_q == cdb_index_i;
    data_d  = match_o ? cdb_result_i : data_q;
    lock_d  = flush_i ? LW'(0) : alloc_i ? alloc_lock_i : match_o ? LW'(0) : lock_q;
    inc_o   = lock_q == LW'(0) && lock_d != LW'(0);
    dec_o   = lock_q != LW'(0) && lock_d == LW'(0);
  end
  always_ff @(posedge clk) begin
    data_q <= rst ? '0 : data_d;
    lock_q <= rst ? '0 : lock_d;
  end
  assign data_o = data_q;
  assign lock_o = lock_q;
endmodule

// File: rtl/reg_lock_file.sv
// reg_lock_file: register file with producer-tag locks cleared by CDB broadcasts.
// Define CDB_BYPASS_EN to forward a matching broadcast to the read ports in the same cycle.
import reg_lock_file_pkg::*;
module reg_lock_file #(
  parameter int DATA_W = reg_lock_file_pkg::DATA_W,
  parameter int LOCK_W = reg_lock_file_pkg::LOCK_W,
  parameter int NREG   = reg_lock_file_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [LOCK_W-1:0] rd_lock1,
  output logic [LOCK_W-1:0] rd_lock2,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [LOCK_W-1:0] alloc_lock,
  input  logic              cdb_in_valid,
  input  logic [LOCK_W-1:0] cdb_in_index,
  input  logic [DATA_W-1:0] cdb_in_result,
  input  logic              flush,
  output logic [CNT_W-1:0]  locked_count,
  output logic              lock_stall
);
  localparam logic [CNT_W-1:0] STALL_TH = CNT_W'((1 << LOCK_W) - 1);
  logic              cdb_v;
  logic [DATA_W-1:0] data_w [NREG];
  logic [LOCK_W-1:0] lock_w [NREG];
  logic [NREG-1:0]   match_w, inc_w, dec_w;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  assign cdb_v = cdb_in_valid && cdb_in_index != LOCK_W'(0);
  // Register 0 is hardwired: never locked, never written.
  assign data_w[0]  = '0;
  assign lock_w[0]  = '0;
  assign match_w[0] = 1'b0;
  assign inc_w[0]   = 1'b0;
  assign dec_w[0]   = 1'b0;
  for (genvar g = 1; g < NREG; g++) begin : g_ent
    reg_lock_entry #(.DW(DATA_W), .LW(LOCK_W)) u_ent (
      .clk         (clk),
      .rst         (rst),
      .alloc_i     (alloc_en && alloc_addr == ADDR_W'(g)),
      .alloc_lock_i(alloc_lock),
      .cdb_valid_i (cdb_v),
      .cdb_index_i (cdb_in_index),
      .cdb_result_i(cdb_in_result),
      .flush_i     (flush),
      .data_o      (data_w[g]),
      .lock_o      (lock_w[g]),
      .match_o     (match_w[g]),
      .inc_o       (inc_w[g]),
      .dec_o       (dec_w[g])
    );
  end
`ifdef CDB_BYPASS_EN
  assign rd_data1 = match_w[rd_addr1] ? cdb_in_result : data_w[rd_addr1];
  assign rd_data2 = match_w[rd_addr2] ? cdb_in_result : data_w[rd_addr2];
  assign rd_lock1 = match_w[rd_addr1] ? LOCK_W'(0) : lock_w[rd_addr1];
  assign rd_lock2 = match_w[rd_addr2] ? LOCK_W'(0) : lock_w[rd_addr2];
`else
  assign rd_data1 = data_w[rd_addr1];
  assign rd_data2 = data_w[rd_addr2];
  assign rd_lock1 = lock_w[rd_addr1];
  assign rd_lock2 = lock_w[rd_addr2];
`endif
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREG; i++) cnt_d = cnt_d + CNT_W'(inc_w[i]) - CNT_W'(dec_w[i]);
    cnt_d = flush ? '0 : cnt_d;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign locked_count = cnt_q;
  assign lock_stall   = cnt_q >= STALL_TH;
endmodule

// File: tb/tb_reg_lock_file.sv
// tb_reg_lock_file: scoreboard bench for reg_lock_file against an array-based reference model
module tb_reg_lock_file;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, alloc_en, cdb_in_valid, flush, lock_stall;
  logic [4:0] rd_addr1, rd_addr2, alloc_addr;
  logic [31:0] rd_data1, rd_data2, cdb_in_result;
  logic [2:0] rd_lock1, rd_lock2, alloc_lock, cdb_in_index;
  logic [5:0] locked_count;
  reg_lock_file dut (
    .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_lock1(rd_lock1), .rd_lock2(rd_lock2),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_lock(alloc_lock),
    .cdb_in_valid(cdb_in_valid), .cdb_in_index(cdb_in_index), .cdb_in_result(cdb_in_result),
    .flush(flush), .locked_count(locked_count), .lock_stall(lock_stall)
  );
  typedef struct {
    bit chk;
    int id;
    logic [31:0] d1, d2;
    logic [2:0] l1, l2;
    logic [5:0] cnt;
    logic stall;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int compared = 0, mismatched = 0, nstep = 0;
  logic [31:0] m_data [32];
  logic [2:0] m_lock [32];
  bit m_ok = 0;
  function automatic void model_read(input logic [4:0] a, output logic [31:0] d, output logic [2:0] l);
    d = m_data[a];
    l = m_lock[a];
`ifdef CDB_BYPASS_EN
    if (cdb_in_valid && cdb_in_index != 0 && l == cdb_in_index) begin
      d = cdb_in_result;
      l = 0;
    end
`endif
  endfunction
  task automatic step(input bit r, input logic [4:0] a1, a2, input bit ae, input logic [4:0] aa,
                      input logic [2:0] al, input bit cv, input logic [2:0] ci, input logic [31:0] cr, input bit fl);
    exp_t x;
    int n;
    @(posedge clk);
    #1;
    rst = r; rd_addr1 = a1; rd_addr2 = a2; alloc_en = ae; alloc_addr = aa; alloc_lock = al;
    cdb_in_valid = cv; cdb_in_index = ci; cdb_in_result = cr; flush = fl;
    x.chk = m_ok;
    x.id = nstep++;
    model_read(a1, x.d1, x.l1);
    model_read(a2, x.d2, x.l2);
    n = 0;
    for (int i = 0; i < 32; i++) if (m_lock[i] != 0) n++;
    x.cnt = 6'(n);
    x.stall = n >= 7;
    q.push_back(x);
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_data[i] = 0;
        m_lock[i] = 0;
      end
      m_ok = 1;
    end else if (m_ok) begin
      for (int i = 1; i < 32; i++) begin
        bit hit;
        hit = cv && ci != 0 && m_lock[i] == ci;
        if (hit) m_data[i] = cr;
        if (fl) m_lock[i] = 0;
        else if (ae && aa == 5'(i)) m_lock[i] = al;
        else if (hit) m_lock[i] = 0;
      end
    end
  endtask
  task automatic rd(input logic [4:0] a1, a2);
    step(0, a1, a2, 0, 0, 0, 0, 0, 0, 0);
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.chk) begin
        compared++;
        if (rd_data1 !== e.d1 || rd_lock1 !== e.l1 || rd_data2 !== e.d2 || rd_lock2 !== e.l2 ||
            locked_count !== e.cnt || lock_stall !== e.stall) begin
          mismatched++;
          $display("FAIL step%0d outputs: got d1=%h l1=%0d d2=%h l2=%0d cnt=%0d stall=%0b, want d1=%h l1=%0d d2=%h l2=%0d cnt=%0d stall=%0b",
                   e.id, rd_data1, rd_lock1, rd_data2, rd_lock2, locked_count, lock_stall,
                   e.d1, e.l1, e.d2, e.l2, e.cnt, e.stall);
        end
      end
    end
  end
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 0, 1, 6, 3, 1, 1, 32'hDEAD, 1);
    rd(5, 0);
    step(0, 3, 5, 1, 3, 2, 0, 0, 0, 0);
    step(0, 3, 0, 0, 0, 0, 1, 2, 32'h1234, 0);
    rd(3, 0);
    step(0, 4, 3, 1, 4, 1, 0, 0, 0, 0);
    step(0, 4, 0, 1, 4, 3, 0, 0, 0, 0);
    step(0, 4, 0, 0, 0, 0, 1, 1, 32'hAA, 0);
    rd(4, 0);
    step(0, 7, 4, 1, 7, 5, 0, 0, 0, 0);
    step(0, 7, 0, 1, 7, 5, 1, 5, 32'h55, 0);
    rd(7, 0);
    step(0, 0, 0, 1, 0, 6, 1, 0, 32'h77, 0);
    step(0, 7, 4, 0, 0, 0, 1, 5, 32'h66, 0);
    for (int i = 1; i <= 7; i++) step(0, 5'(7 + i), 4, 1, 5'(7 + i), 3'(i), 0, 0, 0, 0);
    rd(8, 14);
    step(0, 8, 3, 1, 20, 2, 1, 3, 32'hC0DE, 1);
    rd(3, 4);
    step(0, 2, 0, 1, 2, 4, 0, 0, 0, 0);
    step(0, 2, 0, 0, 0, 0, 1, 4, 32'h99, 0);
    rd(2, 0);
    step(0, 2, 0, 0, 0, 0, 0, 4, 32'h11, 0);
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 99) == 0, 5'($urandom), 5'($urandom),
           $urandom_range(0, 9) < 6, 5'($urandom), 3'($urandom_range(1, 7)),
           $urandom_range(0, 9) < 5, 3'($urandom), $urandom, $urandom_range(0, 29) == 0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    if (compared < 12) begin
      mismatched++;
      $display("FAIL coverage: got %0d compared, want at least 12", compared);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
